// File: rtl/efuse_usr_bank.sv
// Clocked model of a multi-word one-time-programmable user eFuse bank.
// Provides addressed reads, a timed OR-only program sequence, a lock fuse and error pulses.
//
// state | meaning
// IDLE  | accepting lock / program / read requests
// RD    | read accepted, data and valid registered on next edge
// PROG  | program in progress, counter running down to commit
module efuse_usr_bank #(
  parameter int unsigned                     WORD_WIDTH      = 32,
  parameter int unsigned                     NUM_WORDS       = 4,
  parameter logic [WORD_WIDTH*NUM_WORDS-1:0] SIM_EFUSE_VALUE = '0,
  parameter logic                            SIM_LOCK_VALUE  = 1'b0,
  parameter int unsigned                     PROG_CYCLES     = 8,
  localparam int unsigned                    AW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
  input  logic                            CLK,
  input  logic                            RST,
  output logic [WORD_WIDTH*NUM_WORDS-1:0] EFUSEUSR,
  input  logic [AW-1:0]                   ADDR,
  input  logic                            RD_EN,
  output logic [WORD_WIDTH-1:0]           RD_DATA,
  output logic                            RD_VALID,
  input  logic                            PROG_EN,
  input  logic [WORD_WIDTH-1:0]           PROG_DATA,
  input  logic                            LOCK_EN,
  output logic                            BUSY,
  output logic                            DONE,
  output logic                            ERR,
  output logic                            LOCKED
);

  localparam int unsigned CW = $clog2(PROG_CYCLES);
  localparam logic [AW:0] NW_EXT = (AW+1)'(NUM_WORDS);
  localparam logic [CW-1:0] CNT_LOAD = CW'(PROG_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, RD, PROG} state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           count_q;
  logic [AW-1:0]           addr_q;
  logic [WORD_WIDTH-1:0]   data_q;
  logic                    addr_ok;
  logic                    start_rd, start_prog, set_lock, commit, err_d;

  // Nonvolatile storage: loaded once at time zero, untouched by RST.
  logic [WORD_WIDTH*NUM_WORDS-1:0] fuse_q = SIM_EFUSE_VALUE;
  logic                            locked_q = SIM_LOCK_VALUE;

  assign addr_ok = ({1'b0, ADDR} < NW_EXT);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    start_rd   = 1'b0;
    start_prog = 1'b0;
    set_lock   = 1'b0;
    commit     = 1'b0;
    err_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (LOCK_EN) begin
          set_lock = 1'b1;
        end else if (PROG_EN) begin
          if (!addr_ok || locked_q) begin
            err_d = 1'b1;
          end else begin
            start_prog = 1'b1;
            state_d    = PROG;
          end
        end else if (RD_EN) begin
          if (!addr_ok) begin
            err_d = 1'b1;
          end else begin
            start_rd = 1'b1;
            state_d  = RD;
          end
        end
      end
      RD: state_d = IDLE;
      PROG: begin
        if (count_q == '0) begin
          commit  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      count_q  <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      RD_DATA  <= '0;
      RD_VALID <= 1'b0;
      DONE     <= 1'b0;
      ERR      <= 1'b0;
    end else begin
      RD_VALID <= (state_q == RD);
      DONE     <= commit;
      ERR      <= err_d;
      if (start_rd || start_prog) addr_q <= ADDR;
      if (start_prog) begin
        data_q  <= PROG_DATA;
        count_q <= CNT_LOAD;
      end else if (state_q == PROG && count_q != '0) begin
        count_q <= count_q - 1'b1;
      end
      if (state_q == RD) RD_DATA <= fuse_q[int'(addr_q)*WORD_WIDTH +: WORD_WIDTH];
    end
  end

  // commit is only ever raised in PROG, which RST forces back to IDLE, so an abort writes nothing.
  always_ff @(posedge CLK) begin
    if (commit) fuse_q[int'(addr_q)*WORD_WIDTH +: WORD_WIDTH] <=
                  fuse_q[int'(addr_q)*WORD_WIDTH +: WORD_WIDTH] | data_q;
    if (set_lock) locked_q <= 1'b1;
  end

  assign EFUSEUSR = fuse_q;
  assign BUSY     = (state_q != IDLE);
  assign LOCKED   = locked_q;

endmodule

// File: tb/tb_efuse_usr_bank.sv
// Self-checking bench for efuse_usr_bank: directed scenarios plus randomized
// program/read traffic compared against a word-array reference model.
module tb_efuse_usr_bank;

  localparam int WW = 32;
  localparam int NW = 4;
  localparam int NW3 = 3;
  localparam logic [WW*NW-1:0]  INIT  = {32'h0000_0000, 32'h0000_0000, 32'hA5A5_0000, 32'h1234_0001};
  localparam logic [WW*NW3-1:0] INIT3 = {32'hCAFE_0003, 32'h0F0F_0002, 32'h8000_0001};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]       addr = '0;
  logic             rd_en = 1'b0, prog_en = 1'b0, lock_en = 1'b0;
  logic [WW-1:0]    prog_data = '0;
  logic [WW*NW-1:0] efuse;
  logic [WW-1:0]    rd_data;
  logic             rd_valid, busy, done, err, locked;

  logic [1:0]        addr3 = '0;
  logic              rd_en3 = 1'b0, prog_en3 = 1'b0, lock_en3 = 1'b0;
  logic [WW-1:0]     prog_data3 = '0;
  logic [WW*NW3-1:0] efuse3;
  logic [WW-1:0]     rd_data3;
  logic              rd_valid3, busy3, done3, err3, locked3;

  efuse_usr_bank #(.WORD_WIDTH(WW), .NUM_WORDS(NW), .SIM_EFUSE_VALUE(INIT),
                   .SIM_LOCK_VALUE(1'b0), .PROG_CYCLES(8)) u_dut (
    .CLK(clk), .RST(rst), .EFUSEUSR(efuse), .ADDR(addr), .RD_EN(rd_en),
    .RD_DATA(rd_data), .RD_VALID(rd_valid), .PROG_EN(prog_en), .PROG_DATA(prog_data),
    .LOCK_EN(lock_en), .BUSY(busy), .DONE(done), .ERR(err), .LOCKED(locked));

  efuse_usr_bank #(.WORD_WIDTH(WW), .NUM_WORDS(NW3), .SIM_EFUSE_VALUE(INIT3),
                   .SIM_LOCK_VALUE(1'b0), .PROG_CYCLES(8)) u_dut3 (
    .CLK(clk), .RST(rst), .EFUSEUSR(efuse3), .ADDR(addr3), .RD_EN(rd_en3),
    .RD_DATA(rd_data3), .RD_VALID(rd_valid3), .PROG_EN(prog_en3), .PROG_DATA(prog_data3),
    .LOCK_EN(lock_en3), .BUSY(busy3), .DONE(done3), .ERR(err3), .LOCKED(locked3));

  int checks = 0;
  int errors = 0;
  logic [WW-1:0] m_word [NW];
  logic          m_locked;

  function automatic logic [WW*NW-1:0] model_flat();
    logic [WW*NW-1:0] f;
    for (int i = 0; i < NW; i++) f[i*WW +: WW] = m_word[i];
    return f;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_read(input logic [1:0] a, input string tag);
    @(negedge clk); addr = a; rd_en = 1'b1;
    @(negedge clk); rd_en = 1'b0;
    chk({tag, "_early_valid"}, rd_valid, 1'b0);
    @(negedge clk);
    chk({tag, "_valid"}, rd_valid, 1'b1);
    chk({tag, "_data"}, rd_data, m_word[a]);
  endtask

  task automatic do_prog(input logic [1:0] a, input logic [WW-1:0] d, input bit also_rd, input string tag);
    int  n;
    logic saw;
    @(negedge clk); addr = a; prog_data = d; prog_en = 1'b1; rd_en = also_rd;
    @(negedge clk); prog_en = 1'b0; rd_en = 1'b0;
    n = 0; saw = 1'b0;
    while (busy && n < 20) begin
      rd_en = also_rd && (n == 3);
      saw = saw | rd_valid | err | done;
      n++;
      @(negedge clk);
    end
    rd_en = 1'b0;
    m_word[a] = m_word[a] | d;
    chk({tag, "_busy_cycles"}, n, 8);
    chk({tag, "_no_early_pulse"}, saw, 1'b0);
    chk({tag, "_done"}, done, 1'b1);
    chk({tag, "_array"}, efuse, model_flat());
    @(negedge clk);
    chk({tag, "_quiet_after"}, {rd_valid, err, done}, 3'b000);
  endtask

  initial begin
    for (int i = 0; i < NW; i++) m_word[i] = INIT[i*WW +: WW];
    m_locked = 1'b0;

    // reset state
    #12;
    chk("rst_outputs", {busy, rd_valid, done, err, locked}, 5'b0);
    chk("rst_rd_data", rd_data, 32'h0);
    chk("rst_array", efuse, model_flat());
    @(negedge clk); rst = 1'b0;

    // addressed read of initial contents
    do_read(2'd1, "rd_init_w1");
    chk("rd_init_w1_const", rd_data, 32'hA5A5_0000);
    do_read(2'd0, "rd_init_w0");

    // program then OR more bits in
    do_prog(2'd2, 32'h0000_00F0, 1'b0, "prog_w2_a");
    do_prog(2'd2, 32'h0000_000F, 1'b0, "prog_w2_b");
    chk("prog_w2_or_const", efuse[2*WW +: WW], 32'h0000_00FF);
    do_prog(2'd1, 32'h0, 1'b0, "prog_noop");

    // reset aborts a program in flight
    @(negedge clk); addr = 2'd3; prog_data = 32'hFFFF_FFFF; prog_en = 1'b1;
    @(negedge clk); prog_en = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_busy_before", busy, 1'b1);
    rst = 1'b1; #1;
    chk("abort_busy_async", busy, 1'b0);
    @(negedge clk); rst = 1'b0;
    repeat (10) begin
      @(negedge clk);
      chk("abort_no_done", {done, busy}, 2'b00);
    end
    chk("abort_array", efuse, model_flat());

    // reset aborts a read in flight
    @(negedge clk); addr = 2'd1; rd_en = 1'b1;
    @(negedge clk); rd_en = 1'b0; rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("rd_abort_no_valid", {rd_valid, rd_data}, 33'h0);

    // simultaneous program+read, and a read strobe while busy
    do_prog(2'd3, 32'h0101_0000, 1'b1, "prog_with_rd");

    // randomized traffic against the model
    for (int k = 0; k < 12; k++) begin
      logic [1:0]    ra;
      logic [WW-1:0] rd;
      ra = 2'($urandom_range(0, NW - 1));
      rd = $urandom() & $urandom();
      if ($urandom_range(0, 1) == 0) do_prog(ra, rd, 1'b0, $sformatf("rand_prog_%0d", k));
      else                             do_read(ra, $sformatf("rand_rd_%0d", k));
    end

    // out-of-range addresses on the 3-word bank
    @(negedge clk); addr3 = 2'd3; rd_en3 = 1'b1;
    @(negedge clk); rd_en3 = 1'b0;
    chk("oor_rd_err", {err3, busy3}, 2'b10);
    @(negedge clk);
    chk("oor_rd_no_valid", {rd_valid3, err3}, 2'b00);
    @(negedge clk); addr3 = 2'd3; prog_data3 = 32'hFFFF_FFFF; prog_en3 = 1'b1;
    @(negedge clk); prog_en3 = 1'b0;
    chk("oor_prog_err", {err3, busy3}, 2'b10);
    repeat (10) @(negedge clk);
    chk("oor_prog_array", {efuse3, done3}, {INIT3, 1'b0});
    @(negedge clk); addr3 = 2'd2; rd_en3 = 1'b1;
    @(negedge clk); rd_en3 = 1'b0;
    @(negedge clk);
    chk("nw3_rd_w2", {rd_valid3, rd_data3}, {1'b1, 32'hCAFE_0003});

    // lock: program rejected, reads still allowed
    @(negedge clk); lock_en = 1'b1;
    @(negedge clk); lock_en = 1'b0; m_locked = 1'b1;
    chk("lock_set", {locked, err, busy}, {m_locked, 2'b00});
    @(negedge clk); addr = 2'd0; prog_data = 32'hFFFF_FFFF; prog_en = 1'b1;
    @(negedge clk); prog_en = 1'b0;
    chk("locked_prog_err", {err, busy}, 2'b10);
    @(negedge clk);
    chk("locked_err_pulse", err, 1'b0);
    repeat (10) @(negedge clk);
    chk("locked_array", {efuse, done}, {model_flat(), 1'b0});
    @(negedge clk); lock_en = 1'b1;
    @(negedge clk); lock_en = 1'b0;
    chk("relock_no_err", {locked, err}, 2'b10);
    do_read(2'd0, "locked_rd_w0");
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("lock_survives_rst", locked, m_locked);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
